priority_arbiter: RTL and testbench
===================================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 8, meaning number of requesters (fixed at 8; other values unsupported).
REQ-002 SHALL provide parameter MAX_HOLD, default 16, meaning maximum consecutive grant cycles before forced release (range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  8  per-requester request level; bit 7 has the highest priority.
REQ-006 SHALL have port gnt  output  8  one-hot grant (all-zero when nothing is granted).
REQ-007 SHALL have port gnt_id  output  3  binary index of the granted requester; 0 when gnt_valid is 0.
REQ-008 SHALL have port gnt_valid  output  1  high while any grant is held.
REQ-009 SHALL have port timeout  output  1  single-cycle pulse on the cycle after a forced release.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT and RELEASE.
REQ-011 IDLE: with req != 0, the highest-index set bit SHALL be granted next cycle (state GRANT); with req == 0, the FSM SHALL stay in IDLE.
REQ-012 Latency SHALL be one cycle: req sampled at edge t produces gnt, gnt_id and gnt_valid registered at edge t+1.
REQ-013 GRANT: the grant SHALL be held while req[gnt_id] stays 1, regardless of higher-priority arrivals (no pre-emption).
REQ-014 GRANT: req[gnt_id] == 0 SHALL move the FSM to RELEASE and clear gnt, gnt_id and gnt_valid on the same edge.
REQ-015 A hold counter SHALL count grant cycles; when MAX_HOLD cycles have elapsed, the FSM SHALL go to RELEASE even with req[gnt_id] still 1, and timeout SHALL pulse for that one cycle.
REQ-016 RELEASE SHALL last exactly one cycle with all grant outputs 0, then return to IDLE.
REQ-017 Minimum spacing between two grants SHALL therefore be two idle-output cycles.
REQ-018 gnt SHALL always be one-hot or zero; gnt_valid SHALL equal |gnt; gnt_id SHALL encode gnt.
REQ-019 Simultaneous timeout and requester drop on the same cycle SHALL be treated as a normal release (timeout stays 0).
REQ-020 The hold counter SHALL clear on entry to GRANT and SHALL saturate rather than wrap.

Reset
REQ-021 While rst_n == 0, the FSM SHALL be in IDLE, gnt = 8'h00, gnt_id = 3'd0, gnt_valid = 0, timeout = 0, the hold counter = 0 and the fairness mask = 0, asynchronously.
REQ-022 Reset asserted during GRANT SHALL drop the grant immediately with no RELEASE cycle; arbitration SHALL restart on the first edge after deassertion.

Configuration
REQ-023 Macro PRIORITY_ARBITER_FAIR_EN: when defined, a released requester index and all indices above it SHALL be masked for the next IDLE arbitration whenever any unmasked request exists; otherwise the unmasked priority result SHALL be used, and the mask SHALL clear after that arbitration.
REQ-024 Without PRIORITY_ARBITER_FAIR_EN, arbitration SHALL be strict fixed priority (MSB wins), with no mask logic present.

Structure
REQ-025 Package priority_arbiter_pkg SHALL hold the FSM state enum, N_REQ_C = 8 and ID_W_C = 3.
REQ-026 Sub-module arb_pri_enc SHALL provide the combinational 8-to-3 MSB-priority encode with a valid flag; it SHALL be instantiated once.

Verification
REQ-027 Reset, then req = 8'h05 -> one cycle later gnt = 8'h04, gnt_id = 2, gnt_valid = 1.
REQ-028 Holder 2 granted, then req = 8'h85 -> gnt stays 8'h04; drop bit 2 -> RELEASE cycle, then gnt = 8'h80.
REQ-029 req = 8'h40 held constant, MAX_HOLD = 16 -> exactly 16 grant cycles, timeout pulses once, 1 RELEASE cycle, then re-grant of bit 6.
REQ-030 With FAIR_EN defined and req = 8'hC0 held -> grants alternate 7, 6, 7, 6; without FAIR_EN -> bit 7 only.
REQ-031 rst_n pulsed low mid-GRANT -> all outputs 0 asynchronously, and arbitration resumes one cycle after release of reset.
REQ-032 Timeout cycle coincides with req[gnt_id] falling -> normal release, timeout = 0.

Source files
------------

// File: rtl/priority_arbiter_pkg.sv
// Shared types and constants for the priority arbiter.
// The FSM state encoding and the requester/ID widths live here so the top
// and the encoder agree on them.
package priority_arbiter_pkg;

  localparam int N_REQ_C = 8;
  localparam int ID_W_C  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Index-to-one-hot conversion for the registered grant vector.
  function automatic logic [N_REQ_C-1:0] id_to_onehot(input logic [ID_W_C-1:0] id);
    logic [N_REQ_C-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_pri_enc.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
// o_valid is high whenever any input bit is set; o_id is 0 otherwise.
module arb_pri_enc
  import priority_arbiter_pkg::*;
(
  input  logic [N_REQ_C-1:0] i_req,
  output logic [ID_W_C-1:0]  o_id,
  output logic               o_valid
);

  // Scan from LSB to MSB so the last (highest) set bit overrides lower ones.
  always_comb begin
    o_id    = '0;
    o_valid = |i_req;
    for (int i = 0; i < N_REQ_C; i++) begin
      if (i_req[i]) o_id = ID_W_C'(i);
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Fixed-priority arbiter with hold timeout and a mandatory release cycle.
// Optional fairness mask is compiled in with PRIORITY_ARBITER_FAIR_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no grant; arbitrate among requests on every edge
// ST_GRANT   | grant held until holder drops or MAX_HOLD cycles elapse
// ST_RELEASE | one cycle with all grant outputs low, then back to IDLE
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [ID_W_C-1:0] gnt_id,
  output logic              gnt_valid,
  output logic              timeout
);

  // Counter value seen during the last permitted grant cycle.
  localparam logic [7:0] HOLD_LAST_C = 8'(MAX_HOLD - 1);

  arb_state_e          r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [ID_W_C-1:0]   r_gnt_id;
  logic                r_gnt_valid;
  logic                r_timeout;
  logic [7:0]          r_hold_cnt;

  logic [N_REQ_C-1:0]  w_enc_in;
  logic [ID_W_C-1:0]   w_enc_id;
  logic                w_enc_valid;
  logic                w_holder_req;

`ifdef PRIORITY_ARBITER_FAIR_EN
  logic [N_REQ_C-1:0]  r_mask;
  logic [N_REQ_C-1:0]  w_masked_req;

  // Prefer requesters below the last holder; fall back to plain priority
  // when nobody below it is asking.
  always_comb begin
    w_masked_req = req & ~r_mask;
    w_enc_in     = (|w_masked_req) ? w_masked_req : req;
  end
`else
  // Strict fixed priority: the encoder sees the raw request vector.
  always_comb begin
    w_enc_in = req;
  end
`endif

  arb_pri_enc u_enc (
    .i_req   (w_enc_in),
    .o_id    (w_enc_id),
    .o_valid (w_enc_valid)
  );

  assign w_holder_req = req[r_gnt_id];

  // Arbitration FSM with registered grant outputs and saturating hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
`ifdef PRIORITY_ARBITER_FAIR_EN
      r_mask      <= '0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_enc_valid) begin
            r_state     <= ST_GRANT;
            r_gnt       <= id_to_onehot(w_enc_id);
            r_gnt_id    <= w_enc_id;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
`ifdef PRIORITY_ARBITER_FAIR_EN
            r_mask      <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // A holder drop wins over an expiring counter: that is a normal release.
          if (!w_holder_req || (r_hold_cnt >= HOLD_LAST_C)) begin
            r_state     <= ST_RELEASE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= w_holder_req;
`ifdef PRIORITY_ARBITER_FAIR_EN
            r_mask      <= 8'hFF << r_gnt_id;
`endif
          end else if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter: the driver pushes the expected
// outputs for each directed cycle, the monitor pops and compares after
// every rising edge.
module tb_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0]  g;
    logic        to;
    logic [15:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_n = 0;

  priority_arbiter #(.N_REQ(8), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] onehot_idx(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] g, input logic to);
    exp_t e;
    e.g   = g;
    e.to  = to;
    e.idx = 16'(vec_n);
    vec_n++;
    exp_q.push_back(e);
  endtask

  // Drive req for the next edge and record what must appear after it.
  task automatic step(input logic [7:0] r, input logic [7:0] g, input logic to);
    @(negedge clk);
    req = r;
    push_exp(g, to);
  endtask

  // Monitor: compare the registered outputs just after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",       int'(e.idx), int'(gnt),       int'(e.g));
      chk("gnt_id",    int'(e.idx), int'(gnt_id),    int'(onehot_idx(e.g)));
      chk("gnt_valid", int'(e.idx), int'(gnt_valid), int'(|e.g));
      chk("timeout",   int'(e.idx), int'(timeout),   int'(e.to));
    end
  end

  initial begin
    logic [7:0] hold_g;
    rst_n = 1'b0;
    req   = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_gnt",       -1, int'(gnt),       0);
    chk("rst_gnt_id",    -1, int'(gnt_id),    0);
    chk("rst_gnt_valid", -1, int'(gnt_valid), 0);
    chk("rst_timeout",   -1, int'(timeout),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic grant and no pre-emption; release then next winner.
    step(8'h05, 8'h04, 1'b0);
    step(8'h05, 8'h04, 1'b0);
    step(8'h85, 8'h04, 1'b0);
    step(8'h85, 8'h04, 1'b0);
    step(8'h81, 8'h00, 1'b0);
    step(8'h81, 8'h00, 1'b0);
`ifdef PRIORITY_ARBITER_FAIR_EN
    step(8'h81, 8'h01, 1'b0);
`else
    step(8'h81, 8'h80, 1'b0);
`endif
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Constant single requester: 16 grant cycles, timeout, release, re-grant.
    for (int i = 0; i < 16; i++) step(8'h40, 8'h40, 1'b0);
    step(8'h40, 8'h00, 1'b1);
    step(8'h40, 8'h00, 1'b0);
    step(8'h40, 8'h40, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Holder drops exactly when the counter would expire: normal release.
    for (int i = 0; i < 16; i++) step(8'h20, 8'h20, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Two contenders held constant across four timeout rounds.
    for (int k = 0; k < 4; k++) begin
`ifdef PRIORITY_ARBITER_FAIR_EN
      hold_g = (k % 2 == 0) ? 8'h80 : 8'h40;
`else
      hold_g = 8'h80;
`endif
      for (int i = 0; i < 16; i++) step(8'hC0, hold_g, 1'b0);
      step(8'hC0, 8'h00, 1'b1);
      step(8'hC0, 8'h00, 1'b0);
    end
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Asynchronous reset mid-grant, then resume on the first edge after release.
    step(8'h10, 8'h10, 1'b0);
    step(8'h10, 8'h10, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt",       -2, int'(gnt),       0);
    chk("async_rst_gnt_id",    -2, int'(gnt_id),    0);
    chk("async_rst_gnt_valid", -2, int'(gnt_valid), 0);
    chk("async_rst_timeout",   -2, int'(timeout),   0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(8'h10, 1'b0);
    step(8'h10, 8'h10, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", -3, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
